// File: rtl/evrf_uop_issue.sv
// uOP issue stage between the scheduler FIFO and the VRF/MVU read ports.
// Holds one uOP, gates issue on tag ordering, MVU availability and downstream credits.
module evrf_uop_issue #(
    parameter int VRFAW   = 9,
    parameter int NTAGW   = 5,
    parameter int RD_LAT  = 2,
    parameter int CREDITS = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_uinst_rdy,
    output logic              o_uinst_rd_en,
    input  logic [1:0]        i_uinst_src,
    input  logic [VRFAW-1:0]  i_uinst_addr,
    input  logic [NTAGW-1:0]  i_uinst_tag,
    input  logic [NTAGW-1:0]  i_tag_done,
    input  logic              i_mvu_valid,
    output logic              o_mvu_rd_en,
    output logic              o_vrf_rd_en,
    output logic [VRFAW-1:0]  o_vrf_rd_addr,
    output logic              o_out_valid,
    output logic [1:0]        o_out_src,
    output logic [NTAGW-1:0]  o_out_tag,
    input  logic              i_credit_ret,
    output logic [15:0]       o_stall_cnt,
    output logic              o_err
);
    localparam int CW = $clog2(CREDITS + 1);
    localparam logic [CW-1:0] CRED_MAX = CW'(CREDITS);
    localparam logic [1:0] SRC_VRF = 2'd1;
    localparam logic [1:0] SRC_ILL = 2'd3;

    typedef enum logic {IDLE, LOADED} state_t;

    state_t               state, state_nxt;
    logic [1:0]           h_src;
    logic [VRFAW-1:0]     h_addr;
    logic [NTAGW-1:0]     h_tag;
    logic [CW-1:0]        credits;
    logic [RD_LAT:1]             vld_pipe;
    logic [RD_LAT:1][1:0]        src_pipe;
    logic [RD_LAT:1][NTAGW-1:0]  tag_pipe;

    logic pop, issue, drop, stall, src_ok, ret_ovf;

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        issue     = 1'b0;
        drop      = 1'b0;
        stall     = 1'b0;
        src_ok    = (h_src == SRC_VRF) ? (h_tag <= i_tag_done) : i_mvu_valid;
        case (state)
            IDLE: begin
                if (i_uinst_rdy) begin
                    pop       = 1'b1;
                    state_nxt = LOADED;
                end
            end
            LOADED: begin
                if (h_src == SRC_ILL)
                    drop = 1'b1;
                else if (credits != '0 && src_ok)
                    issue = 1'b1;
                else
                    stall = 1'b1;
                // Consuming the held uOP lets the next one load in the same cycle
                if (issue || drop) begin
                    pop       = i_uinst_rdy;
                    state_nxt = i_uinst_rdy ? LOADED : IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign ret_ovf       = i_credit_ret && !issue && (credits == CRED_MAX);
    assign o_uinst_rd_en = pop && !rst;
    assign o_vrf_rd_en   = issue && (h_src == SRC_VRF);
    assign o_vrf_rd_addr = o_vrf_rd_en ? h_addr : '0;
    assign o_mvu_rd_en   = issue && (h_src != SRC_VRF);
    assign o_out_valid   = vld_pipe[RD_LAT];
    assign o_out_src     = src_pipe[RD_LAT];
    assign o_out_tag     = tag_pipe[RD_LAT];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            h_src  <= '0;
            h_addr <= '0;
            h_tag  <= '0;
        end else begin
            state <= state_nxt;
            if (pop) begin
                h_src  <= i_uinst_src;
                h_addr <= i_uinst_addr;
                h_tag  <= i_uinst_tag;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            credits     <= CRED_MAX;
            o_stall_cnt <= '0;
            o_err       <= 1'b0;
        end else begin
            if (issue && !i_credit_ret)
                credits <= credits - CW'(1);
            else if (i_credit_ret && !issue && !ret_ovf)
                credits <= credits + CW'(1);
            if (stall && o_stall_cnt != 16'hFFFF)
                o_stall_cnt <= o_stall_cnt + 16'd1;
            if (drop || ret_ovf)
                o_err <= 1'b1;
        end
    end

    // Stage k carries the sideband of the uOP issued k cycles ago
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe <= '0;
            src_pipe <= '0;
            tag_pipe <= '0;
        end else begin
            vld_pipe[1] <= issue;
            src_pipe[1] <= issue ? h_src : 2'd0;
            tag_pipe[1] <= issue ? h_tag : '0;
            for (int k = 2; k <= RD_LAT; k++) begin
                vld_pipe[k] <= vld_pipe[k-1];
                src_pipe[k] <= src_pipe[k-1];
                tag_pipe[k] <= tag_pipe[k-1];
            end
        end
    end
endmodule

// File: tb/tb_evrf_uop_issue.sv
// Scenario bench for evrf_uop_issue: directed cases plus a randomized run
// against a transaction-level reference model.
module tb_evrf_uop_issue;
    localparam int VRFAW = 9, NTAGW = 5, RD_LAT = 2, CREDITS = 4;

    typedef struct {
        logic [1:0]       src;
        logic [VRFAW-1:0] addr;
        logic [NTAGW-1:0] tag;
    } uop_t;

    logic clk = 1'b0, rst = 1'b1;
    logic i_uinst_rdy = 0, i_mvu_valid = 0, i_credit_ret = 0;
    logic [1:0] i_uinst_src = 0;
    logic [VRFAW-1:0] i_uinst_addr = 0;
    logic [NTAGW-1:0] i_uinst_tag = 0, i_tag_done = 0;
    logic o_uinst_rd_en, o_mvu_rd_en, o_vrf_rd_en, o_out_valid, o_err;
    logic [VRFAW-1:0] o_vrf_rd_addr;
    logic [1:0] o_out_src;
    logic [NTAGW-1:0] o_out_tag;
    logic [15:0] o_stall_cnt;

    evrf_uop_issue #(.VRFAW(VRFAW), .NTAGW(NTAGW), .RD_LAT(RD_LAT), .CREDITS(CREDITS)) dut (
        .clk(clk), .rst(rst), .i_uinst_rdy(i_uinst_rdy), .o_uinst_rd_en(o_uinst_rd_en),
        .i_uinst_src(i_uinst_src), .i_uinst_addr(i_uinst_addr), .i_uinst_tag(i_uinst_tag),
        .i_tag_done(i_tag_done), .i_mvu_valid(i_mvu_valid), .o_mvu_rd_en(o_mvu_rd_en),
        .o_vrf_rd_en(o_vrf_rd_en), .o_vrf_rd_addr(o_vrf_rd_addr), .o_out_valid(o_out_valid),
        .o_out_src(o_out_src), .o_out_tag(o_out_tag), .i_credit_ret(i_credit_ret),
        .o_stall_cnt(o_stall_cnt), .o_err(o_err));

    always #5 clk = ~clk;

    int total = 0, bad = 0;
    uop_t uq[$];
    logic c_rd, c_vrf, c_mvu, c_ov, c_err;
    logic [VRFAW-1:0] c_addr;
    logic [1:0] c_osrc;
    logic [NTAGW-1:0] c_otag;
    logic [15:0] c_stall;

    // One cycle: present the scheduler FIFO head, sample outputs, pop on rd_en.
    task automatic step();
        i_uinst_rdy = (uq.size() > 0);
        if (uq.size() > 0) begin
            i_uinst_src = uq[0].src; i_uinst_addr = uq[0].addr; i_uinst_tag = uq[0].tag;
        end else begin
            i_uinst_src = 0; i_uinst_addr = 0; i_uinst_tag = 0;
        end
        #1;
        c_rd = o_uinst_rd_en; c_vrf = o_vrf_rd_en; c_mvu = o_mvu_rd_en; c_addr = o_vrf_rd_addr;
        c_ov = o_out_valid; c_osrc = o_out_src; c_otag = o_out_tag;
        c_stall = o_stall_cnt; c_err = o_err;
        if (o_uinst_rd_en && uq.size() > 0) void'(uq.pop_front());
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        i_mvu_valid = 0; i_credit_ret = 0; i_tag_done = 0;
        uq.delete();
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic push_mvu(input int n);
        for (int k = 0; k < n; k++) uq.push_back('{2'd0, VRFAW'(k), NTAGW'(k)});
    endtask

    task automatic test_reset();
        rst = 1'b1;
        i_uinst_rdy = 1; i_uinst_src = 1; i_mvu_valid = 1; i_credit_ret = 1;
        #1;
        total++;
        if ({o_uinst_rd_en, o_vrf_rd_en, o_mvu_rd_en, o_out_valid, o_err} !== 5'b0 ||
            o_stall_cnt !== 16'd0 || o_vrf_rd_addr !== '0) begin
            bad++;
            $display("FAIL reset_outputs got rd=%b vrf=%b mvu=%b ov=%b err=%b stall=%0d exp all 0",
                     o_uinst_rd_en, o_vrf_rd_en, o_mvu_rd_en, o_out_valid, o_err, o_stall_cnt);
        end
        do_reset();
        step();
        total++;
        if (c_rd !== 1'b0 || c_ov !== 1'b0 || c_err !== 1'b0 || c_stall !== 16'd0) begin
            bad++;
            $display("FAIL post_reset_idle got rd=%b ov=%b err=%b stall=%0d exp 0", c_rd, c_ov, c_err, c_stall);
        end
    endtask

    task automatic test_back_to_back();
        logic ev, eo;
        do_reset();
        for (int a = 0; a < 8; a++) uq.push_back('{2'd1, VRFAW'(a), NTAGW'(0)});
        for (int n = 0; n < 13; n++) begin
            step();
            ev = (n >= 1 && n <= 8);
            eo = (n >= 3 && n <= 10);
            total++;
            if (c_vrf !== ev || c_mvu !== 1'b0 || (ev && c_addr !== VRFAW'(n - 1))) begin
                bad++;
                $display("FAIL b2b_vrf_rd n=%0d got en=%b mvu=%b addr=%0d exp en=%b addr=%0d", n, c_vrf, c_mvu, c_addr, ev, n - 1);
            end
            total++;
            if (c_ov !== eo || (eo && (c_osrc !== 2'd1 || c_otag !== '0))) begin
                bad++;
                $display("FAIL b2b_out_valid n=%0d got ov=%b src=%0d exp ov=%b src=1", n, c_ov, c_osrc, eo);
            end
            total++;
            if (c_rd !== (n <= 7)) begin
                bad++;
                $display("FAIL b2b_uinst_rd_en n=%0d got %b exp %b", n, c_rd, (n <= 7));
            end
            i_credit_ret = c_ov;
        end
        i_credit_ret = 0;
    endtask

    task automatic test_tag_stall();
        do_reset();
        uq.push_back('{2'd1, VRFAW'(5), NTAGW'(3)});
        i_tag_done = 1;
        for (int n = 0; n < 10; n++) begin
            if (n == 6) i_tag_done = 3;
            step();
            total++;
            if (c_vrf !== (n == 6) || (n == 6 && c_addr !== VRFAW'(5))) begin
                bad++;
                $display("FAIL tag_stall_issue n=%0d got en=%b addr=%0d exp en=%b addr=5", n, c_vrf, c_addr, (n == 6));
            end
            if (n == 6 || n == 9) begin
                total++;
                if (c_stall !== 16'd5) begin
                    bad++;
                    $display("FAIL tag_stall_cnt n=%0d got %0d exp 5", n, c_stall);
                end
            end
            if (n == 8) begin
                total++;
                if (c_ov !== 1'b1 || c_osrc !== 2'd1 || c_otag !== NTAGW'(3)) begin
                    bad++;
                    $display("FAIL tag_stall_out got ov=%b src=%0d tag=%0d exp 1/1/3", c_ov, c_osrc, c_otag);
                end
            end
        end
    endtask

    task automatic test_credits();
        int issues = 0, outs = 0;
        do_reset();
        push_mvu(6);
        i_mvu_valid = 1;
        for (int n = 0; n < 12; n++) begin
            i_credit_ret = (n == 8);
            step();
            issues += int'(c_mvu);
            outs += int'(c_ov);
            if (n == 7) begin
                total++;
                if (issues != 4) begin
                    bad++;
                    $display("FAIL credits_exhaust got issues=%0d exp 4", issues);
                end
            end
            if (n == 9) begin
                total++;
                if (c_mvu !== 1'b1) begin
                    bad++;
                    $display("FAIL credits_fifth_issue got %b exp 1", c_mvu);
                end
            end
        end
        total++;
        if (issues != 5 || outs != 5) begin
            bad++;
            $display("FAIL credits_total got issues=%0d outs=%0d exp 5/5", issues, outs);
        end
        i_credit_ret = 0;
    endtask

    task automatic test_illegal_flush();
        do_reset();
        uq.push_back('{2'd3, VRFAW'(26), NTAGW'(2)});
        uq.push_back('{2'd2, VRFAW'(0), NTAGW'(7)});
        i_mvu_valid = 1;
        for (int n = 0; n < 6; n++) begin
            step();
            if (n == 1) begin
                total++;
                if (c_vrf !== 1'b0 || c_mvu !== 1'b0 || c_rd !== 1'b1) begin
                    bad++;
                    $display("FAIL illegal_drop got vrf=%b mvu=%b rd=%b exp 0/0/1", c_vrf, c_mvu, c_rd);
                end
            end
            if (n == 2) begin
                total++;
                if (c_err !== 1'b1 || c_mvu !== 1'b1) begin
                    bad++;
                    $display("FAIL illegal_err_flush got err=%b mvu=%b exp 1/1", c_err, c_mvu);
                end
            end
            if (n == 3 || n == 4) begin
                total++;
                if (c_ov !== (n == 4) || (n == 4 && (c_osrc !== 2'd2 || c_otag !== NTAGW'(7)))) begin
                    bad++;
                    $display("FAIL flush_out n=%0d got ov=%b src=%0d tag=%0d exp ov=%b src=2 tag=7", n, c_ov, c_osrc, c_otag, (n == 4));
                end
            end
        end
        total++;
        if (c_stall !== 16'd0) begin
            bad++;
            $display("FAIL illegal_no_stall got %0d exp 0", c_stall);
        end
    endtask

    task automatic test_reset_mid();
        int issues = 0, outs = 0;
        do_reset();
        uq.push_back('{2'd1, VRFAW'(4), NTAGW'(0)});
        step(); step();
        total++;
        if (c_vrf !== 1'b1) begin
            bad++;
            $display("FAIL rstmid_issue got %b exp 1", c_vrf);
        end
        rst = 1'b1;
        #1;
        total++;
        if (o_out_valid !== 1'b0 || o_vrf_rd_en !== 1'b0 || o_uinst_rd_en !== 1'b0) begin
            bad++;
            $display("FAIL rstmid_during got ov=%b vrf=%b rd=%b exp 0", o_out_valid, o_vrf_rd_en, o_uinst_rd_en);
        end
        @(negedge clk);
        rst = 1'b0;
        push_mvu(5);
        i_mvu_valid = 1;
        for (int n = 0; n < 9; n++) begin
            step();
            if (n == 0) begin
                total++;
                if (c_rd !== 1'b1 || c_mvu !== 1'b0 || c_vrf !== 1'b0) begin
                    bad++;
                    $display("FAIL rstmid_first_cycle got rd=%b mvu=%b vrf=%b exp 1/0/0", c_rd, c_mvu, c_vrf);
                end
            end
            if (n < 3) outs += int'(c_ov);
            issues += int'(c_mvu);
        end
        total++;
        if (outs != 0 || issues != 4) begin
            bad++;
            $display("FAIL rstmid_flushed got stale_outs=%0d issues=%0d exp 0/4", outs, issues);
        end
    endtask

    task automatic test_credit_overflow();
        int issues = 0;
        do_reset();
        i_credit_ret = 1;
        step();
        i_credit_ret = 0;
        total++;
        if (c_err !== 1'b0) begin
            bad++;
            $display("FAIL ovf_err_before got %b exp 0", c_err);
        end
        step();
        total++;
        if (c_err !== 1'b1) begin
            bad++;
            $display("FAIL ovf_err_set got %b exp 1", c_err);
        end
        push_mvu(6);
        i_mvu_valid = 1;
        for (int n = 0; n < 10; n++) begin
            step();
            issues += int'(c_mvu);
        end
        total++;
        if (issues != CREDITS) begin
            bad++;
            $display("FAIL ovf_credits_held got issues=%0d exp %0d", issues, CREDITS);
        end
    endtask

    task automatic test_random();
        bit m_have = 0, m_err = 0, issue, done;
        uop_t m_h;
        int m_cred = CREDITS, m_stall = 0;
        int due_q[$];
        uop_t out_q[$];
        logic e_rd, e_vrf, e_mvu, e_ov;
        logic [VRFAW-1:0] e_addr;
        do_reset();
        for (int n = 0; n < 400; n++) begin
            if (uq.size() < 3 && $urandom_range(0, 2) != 0)
                uq.push_back('{($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2)),
                               VRFAW'($urandom), NTAGW'($urandom_range(0, 7))});
            i_tag_done = NTAGW'($urandom_range(0, 7));
            i_mvu_valid = ($urandom_range(0, 3) != 0);
            i_credit_ret = ($urandom_range(0, 2) == 0);
            step();
            e_rd = 0; e_vrf = 0; e_mvu = 0; e_addr = '0; issue = 0; done = 0;
            if (!m_have) e_rd = i_uinst_rdy;
            else if (m_h.src == 2'd3) done = 1;
            else if (m_cred > 0 && (m_h.src == 2'd1 ? (m_h.tag <= i_tag_done) : i_mvu_valid)) begin
                issue = 1; done = 1;
            end
            if (done) e_rd = i_uinst_rdy;
            if (issue && m_h.src == 2'd1) begin e_vrf = 1; e_addr = m_h.addr; end
            if (issue && m_h.src != 2'd1) e_mvu = 1;
            e_ov = (due_q.size() > 0 && due_q[0] == n);
            total++;
            if (c_rd !== e_rd || c_vrf !== e_vrf || c_mvu !== e_mvu || c_addr !== e_addr) begin
                bad++;
                $display("FAIL rand_issue n=%0d got rd=%b vrf=%b mvu=%b addr=%0d exp rd=%b vrf=%b mvu=%b addr=%0d",
                         n, c_rd, c_vrf, c_mvu, c_addr, e_rd, e_vrf, e_mvu, e_addr);
            end
            total++;
            if (c_ov !== e_ov || (e_ov && (c_osrc !== out_q[0].src || c_otag !== out_q[0].tag))) begin
                bad++;
                $display("FAIL rand_out n=%0d got ov=%b src=%0d tag=%0d exp ov=%b", n, c_ov, c_osrc, c_otag, e_ov);
            end
            total++;
            if (c_stall !== 16'(m_stall) || c_err !== m_err) begin
                bad++;
                $display("FAIL rand_status n=%0d got stall=%0d err=%b exp stall=%0d err=%b", n, c_stall, c_err, m_stall, m_err);
            end
            if (e_ov) begin void'(due_q.pop_front()); void'(out_q.pop_front()); end
            if (m_have && !done && m_h.src != 2'd3 && m_stall < 65535) m_stall++;
            if (m_have && m_h.src == 2'd3) m_err = 1;
            if (i_credit_ret && !issue && m_cred == CREDITS) m_err = 1;
            else m_cred = m_cred + int'(i_credit_ret) - int'(issue);
            if (issue) begin due_q.push_back(n + RD_LAT); out_q.push_back(m_h); end
            if (e_rd) begin
                m_have = 1; m_h = '{i_uinst_src, i_uinst_addr, i_uinst_tag};
            end else if (done) m_have = 0;
        end
        i_credit_ret = 0;
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_tag_stall();
        test_credits();
        test_illegal_flush();
        test_reset_mid();
        test_credit_overflow();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/evrf_uop_issue.md
EVRF_UOP_ISSUE -- requirements
Module: evrf_uop_issue

Interface
REQ-001 SHALL have parameter VRFAW, default 9: VRF address width.
REQ-002 SHALL have parameter NTAGW, default 5: tag width.
REQ-003 SHALL have parameter RD_LAT, default 2, legal range 1..4: VRF read latency in cycles.
REQ-004 SHALL have parameter CREDITS, default 4, legal range 1..15: downstream buffer credits; CW = $clog2(CREDITS+1).
REQ-005 SHALL have port clk, input, 1 bit: single clock; all logic is rising-edge.
REQ-006 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have port i_uinst_rdy, input, 1 bit: uOP available from the scheduler output FIFO.
REQ-008 SHALL have port o_uinst_rd_en, output, 1 bit: pops one uOP from that FIFO.
REQ-009 SHALL have port i_uinst_src, input, 2 bits: 0 = MVU, 1 = VRF, 2 = FLUSH_MVU, 3 = illegal.
REQ-010 SHALL have ports i_uinst_addr (input, VRFAW bits) and i_uinst_tag (input, NTAGW bits): uOP fields.
REQ-011 SHALL have port i_tag_done, input, NTAGW bits: highest write-back-committed tag.
REQ-012 SHALL have ports i_mvu_valid (input, 1 bit) and o_mvu_rd_en (output, 1 bit): MVU result FIFO non-empty and its pop.
REQ-013 SHALL have ports o_vrf_rd_en (output, 1 bit) and o_vrf_rd_addr (output, VRFAW bits): VRF read request.
REQ-014 SHALL have ports o_out_valid (output, 1 bit), o_out_src (output, 2 bits) and o_out_tag (output, NTAGW bits): sideband aligned to read data.
REQ-015 SHALL have port i_credit_ret, input, 1 bit: downstream returns one credit.
REQ-016 SHALL have port o_stall_cnt, output, 16 bits: saturating count of stall cycles.
REQ-017 SHALL have port o_err, output, 1 bit: sticky error flag.

Function
REQ-018 SHALL implement a two-state FSM: IDLE (holding register empty) and LOADED (holding register holds one uOP).
REQ-019 SHALL, in IDLE with i_uinst_rdy=1, assert o_uinst_rd_en for one cycle, capture src/addr/tag into the holding register and enter LOADED on the next cycle.
REQ-020 SHALL, in LOADED, issue when credits > 0 and the source condition holds: VRF requires i_uinst_tag held <= i_tag_done (unsigned); MVU and FLUSH require i_mvu_valid=1.
REQ-021 SHALL, on issue of a VRF uOP, assert o_vrf_rd_en combinationally with o_vrf_rd_addr equal to the held address; o_mvu_rd_en stays 0.
REQ-022 SHALL, on issue of an MVU or FLUSH uOP, assert o_mvu_rd_en combinationally; o_vrf_rd_en stays 0 and o_vrf_rd_addr is 0.
REQ-023 SHALL, on issue with i_uinst_rdy=1, assert o_uinst_rd_en in the same cycle, reload the holding register and stay in LOADED (one uOP per cycle sustained); otherwise return to IDLE.
REQ-024 SHALL, when a held uOP has src=3, drop it without issuing, set o_err, consume no credit and follow the REQ-023 reload/return rule.
REQ-025 SHALL push {src, tag} into an RD_LAT-deep shift pipeline on issue so that o_out_valid is asserted exactly RD_LAT cycles after the issue cycle, for every source.
REQ-026 SHALL decrement the CW-bit credit counter on issue and increment it on i_credit_ret; simultaneous issue and return leave the counter unchanged.
REQ-027 SHALL, on i_credit_ret while credits == CREDITS with no simultaneous issue, hold the counter at CREDITS and set o_err.
REQ-028 SHALL increment o_stall_cnt each cycle the FSM is in LOADED with a legal uOP and does not issue, saturating at 0xFFFF.
REQ-029 SHALL never assert o_uinst_rd_en while i_uinst_rdy=0, and never assert o_mvu_rd_en while i_mvu_valid=0.

Reset
REQ-030 SHALL, on rst assertion, asynchronously force state=IDLE, the holding register and pipeline to 0, credits=CREDITS, o_stall_cnt=0 and o_err=0, with all outputs 0.
REQ-031 SHALL discard in-flight pipeline entries on reset mid-operation (no o_out_valid after reset) and issue nothing in the first cycle after deassertion.

Verification
REQ-032 SHALL be verified with: 8 back-to-back VRF uOPs at addresses 0..7, tag 0, i_tag_done=0, credits returned each cycle -> 8 consecutive o_vrf_rd_en cycles, o_out_valid on cycles 3..10 for RD_LAT=2.
REQ-033 SHALL be verified with: a VRF uOP with tag 3 while i_tag_done=1, raised to 3 after 5 cycles -> o_stall_cnt=5, then the issue follows.
REQ-034 SHALL be verified with: 6 MVU uOPs, i_mvu_valid=1 and no credit returns -> exactly 4 issues, then a stall; one i_credit_ret -> a 5th issue.
REQ-035 SHALL be verified with: src=3 uOP followed by a FLUSH uOP -> o_err=1, no read for the illegal uOP, and the FLUSH emits o_out_src=2.
REQ-036 SHALL be verified with: rst asserted one cycle after an issue -> no o_out_valid, credits=4, state IDLE.
REQ-037 SHALL be verified with: i_credit_ret at full credits with no issue -> o_err=1 and the counter stays 4.
